// File: rtl/bus_xfer_ctrl.sv
// Round-robin arbitrated register-to-register transfer controller for a shared bus.
// Define BUS_TURNAROUND_EN to insert one dead TURN cycle after every ACK.
module bus_xfer_ctrl #(
    parameter  int NREQ = 4,
    parameter  int NREG = 4,
    localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int RW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*IW-1:0] src,
    input  logic [NREQ*IW-1:0] dst,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [NREG-1:0]    oe,
    output logic [NREG-1:0]    load,
    output logic               err,
    output logic               busy
);

`ifdef BUS_TURNAROUND_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_LOAD,
        ST_ACK,
        ST_TURN
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_LOAD,
        ST_ACK
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [RW-1:0] win_q, win_d;
    logic [IW-1:0] src_l_q, src_l_d;
    logic [IW-1:0] dst_l_q, dst_l_d;
    logic [RW-1:0] last_grant_q, last_grant_d;

    logic [IW-1:0]   src_idx [NREQ];
    logic [IW-1:0]   dst_idx [NREQ];
    logic [NREQ-1:0] win_onehot;
    logic [NREG-1:0] src_onehot;
    logic [NREG-1:0] dst_onehot;
    logic            same_idx;

    logic            pick_valid;
    logic [RW-1:0]   pick;
    logic [RW-1:0]   cand;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign src_idx[gi]    = src[gi*IW +: IW];
        assign dst_idx[gi]    = dst[gi*IW +: IW];
        assign win_onehot[gi] = (win_q == RW'(gi));
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg_dec
        assign src_onehot[gi] = (src_l_q == IW'(gi));
        assign dst_onehot[gi] = (dst_l_q == IW'(gi));
    end

    assign same_idx = (src_l_q == dst_l_q);

    // Rotating priority: the requester just after the last winner is checked first.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = RW'((int'(last_grant_q) + k) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        src_l_d      = src_l_q;
        dst_l_d      = dst_l_q;
        last_grant_d = last_grant_q;
        gnt          = '0;
        ack          = '0;
        oe           = '0;
        load         = '0;
        err          = 1'b0;
        busy         = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_DRIVE;
                    win_d   = pick;
                    src_l_d = src_idx[pick];
                    dst_l_d = dst_idx[pick];
                end
            end
            ST_DRIVE: begin
                gnt = win_onehot;
                oe  = src_onehot;
                // A self-copy has nothing to load, so it completes straight away.
                if (same_idx) begin
                    state_d      = ST_ACK;
                    last_grant_d = win_q;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                gnt          = win_onehot;
                oe           = src_onehot;
                load         = dst_onehot;
                state_d      = ST_ACK;
                last_grant_d = win_q;
            end
            ST_ACK: begin
                ack = win_onehot;
                err = same_idx;
`ifdef BUS_TURNAROUND_EN
                state_d = ST_TURN;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef BUS_TURNAROUND_EN
            ST_TURN: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            win_q        <= '0;
            src_l_q      <= '0;
            dst_l_q      <= '0;
            last_grant_q <= RW'(NREQ - 1);
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            src_l_q      <= src_l_d;
            dst_l_q      <= dst_l_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 Parameter: NREQ, 4, number of transfer requesters.
REQ-002 Parameter: NREG, 4, number of bus-attached N-bit registers; IW = $clog2(NREG).
REQ-003 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  NREQ  per-requester transfer request, level, held until ack.
REQ-006 Port: src  input  NREQ*IW  packed per-requester source register index (slice i = requester i).
REQ-007 Port: dst  input  NREQ*IW  packed per-requester destination register index.
REQ-008 Port: gnt  output  NREQ  one-hot grant, high for the whole transfer.
REQ-009 Port: ack  output  NREQ  one-hot, one-cycle completion pulse.
REQ-010 Port: oe  output  NREG  one-hot source output-enable onto shared bus.
REQ-011 Port: load  output  NREG  one-hot destination load strobe.
REQ-012 Port: err  output  1  one-cycle pulse with ack when src index equals dst index.
REQ-013 Port: busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states: IDLE, DRIVE, LOAD, ACK, plus TURN when BUS_TURNAROUND_EN is defined.
REQ-015 IDLE: if any req bit is high at a clock edge, the controller picks a winner, latches its src/dst and goes to DRIVE; otherwise it stays in IDLE.
REQ-016 Arbitration: round-robin; search starts at (last_grant+1) mod NREQ; last_grant updates on entering ACK.
REQ-017 DRIVE (1 cycle): gnt[w]=1 and oe[src_l]=1; load is all zero.
REQ-018 LOAD (1 cycle): gnt[w]=1, oe[src_l]=1 and load[dst_l]=1.
REQ-019 ACK (1 cycle): ack[w]=1, with gnt, oe and load all zero; the next state is IDLE, or TURN if the macro is defined.
REQ-020 Latency: req sampled in IDLE at edge k gives DRIVE in cycle k+1, LOAD in k+2 and ACK in k+3.
REQ-021 src_l == dst_l: DRIVE goes directly to ACK, skipping LOAD; no load strobe is issued and err=1 during ACK.
REQ-022 Latched src/dst are used for the whole transfer; input changes after the grant are ignored.
REQ-023 If the winner drops req mid-transfer, the transfer still completes and ack still pulses.
REQ-024 At most one oe bit and at most one load bit are high in any cycle.
REQ-025 Outputs are decoded only from registered state and latched indices, with no combinational path from req/src/dst to outputs.

Reset
REQ-026 reset low, asynchronously: state=IDLE; gnt, ack, oe, load, err and busy are all 0; last_grant=NREQ-1, so requester 0 has first priority.
REQ-027 A reset asserted mid-transfer aborts the transfer immediately, with no ack and all oe/load dropped.
REQ-028 After reset deasserts, the first arbitration occurs at the first rising edge with req nonzero.

Configuration
REQ-029 Macro BUS_TURNAROUND_EN defined: after ACK, the controller spends 1 cycle in TURN (oe all zero, busy=1) before IDLE, guaranteeing a dead bus cycle between drivers.
REQ-030 Macro undefined: TURN does not exist, ACK goes directly to IDLE, and back-to-back transfers occur every 4 cycles.

Verification
REQ-031 After reset, req=0001, src0=2, dst0=1 -> cycle+1: oe=0100, gnt=0001; cycle+2: oe=0100, load=0010; cycle+3: ack=0001, err=0.
REQ-032 req=1111 held, re-asserted after each ack -> grants occur in order 0,1,2,3,0 with no requester starved.
REQ-033 req=0010, src1=dst1=3 -> no load pulse; ack=0010 and err=1 two cycles after grant.
REQ-034 reset driven low during LOAD -> oe, load and gnt go 0 without waiting for a clock edge; no ack; the next request is served starting at requester 0.
REQ-035 Winner's req dropped during DRIVE, and src changed -> LOAD still uses the original indices and ack still pulses.
REQ-036 With BUS_TURNAROUND_EN, two back-to-back requests -> exactly one cycle with oe=0000 and busy=1 between ACK and the next IDLE; without the macro, the next DRIVE follows 2 cycles after ACK.
